mem_port_rr_arbiter: RTL and testbench
======================================

Name: mem_port_rr_arbiter

Overview:
- Shares one memory/bus port between NR_REQ requesters (e.g. IFU = 0, LSU = 1) using round-robin arbitration.
- One transaction is outstanding at a time.
- Latches the winning request and drives it downstream. Routes the response back only to the requester that issued it.
- Sits between the pipeline front-end/LSU and the single SRAM/AXI-lite bridge. The per-requester field selection is a keyed mux indexed by the latched grant.

Parameters:
- NR_REQ, 2, number of requesters (≥ 2).
- ADDR_W, 32, address width.
- DATA_W, 64, data width.
- IDX_W, $clog2(NR_REQ), grant index width (derived; not overridden).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NR_REQ  per-requester request valid
- req_ready  out  NR_REQ  per-requester accept (at most one bit set)
- req_addr  in  NR_REQ*ADDR_W  flattened; requester i at [ADDR_W*(i+1)-1 : ADDR_W*i]
- req_wdata  in  NR_REQ*DATA_W  flattened, same packing
- req_wen  in  NR_REQ  1 = write, 0 = read
- resp_valid  out  NR_REQ  one-cycle response strobe to the issuing requester
- resp_rdata  out  DATA_W  response data (broadcast; qualified by resp_valid)
- mem_valid  out  1  downstream request valid
- mem_ready  in  1  downstream accept
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_wen  out  1  latched write enable
- mem_resp_valid  in  1  downstream response strobe
- mem_resp_rdata  in  DATA_W  downstream response data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state = IDLE, rr_ptr = 0, grant_idx = 0, mem_valid = 0, mem_addr/wdata/wen = 0, resp_valid = 0, resp_rdata = 0, busy = 0.
- Reset asserted mid-transaction aborts immediately. The pending downstream transaction is abandoned. Any mem_resp_valid arriving after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, winner selection:
  - The winner w is the first i with req_valid[i] = 1, searching rr_ptr, rr_ptr+1, … modulo NR_REQ.
  - req_ready is combinational, and is one-hot at w only when state = IDLE and some req_valid is set; otherwise req_ready = 0.
  - Handshake fires on req_valid[w] & req_ready[w].
- IDLE, on the firing edge:
  - latch req_addr/wdata/wen of w into mem_* registers;
  - grant_idx ← w;
  - go to ISSUE.
- Accept latency: request handshake at cycle T gives mem_valid = 1 at T+1.
- ISSUE:
  - mem_valid = 1; mem_* stable until mem_ready.
  - On mem_valid & mem_ready go to WAIT.
  - If mem_resp_valid is also high in that same cycle, complete directly (as in WAIT) and go to IDLE.
- WAIT:
  - mem_valid = 0.
  - On mem_resp_valid: resp_rdata ← mem_resp_rdata; resp_valid ← one-hot(grant_idx), registered, so visible the next cycle for exactly 1 cycle; rr_ptr ← (grant_idx+1) mod NR_REQ; go to IDLE.
- mem_resp_valid while in IDLE, or in ISSUE without mem_ready, is dropped. Writes still require a response strobe.
- Back-to-back: resp_valid may be high in the same cycle as a new IDLE acceptance; this is legal.
- req_valid deasserting while not granted is legal. No request is latched until its handshake fires.
- rr_ptr update wraps: grant_idx = NR_REQ-1 gives rr_ptr = 0.
- Fairness: with all requesters continuously valid, grants rotate 0, 1, …, NR_REQ-1, 0. No requester waits more than NR_REQ-1 transactions.
- Single outstanding transaction; no buffering beyond the one latched request.

Test Plan:
- Single read, NR_REQ = 2:
  - Stimulus: req_valid = 01, addr0 = 0x8000_0000; mem_ready held 1; response 0xDEAD_BEEF two cycles after acceptance.
  - Required: req_ready = 01 at T; mem_valid at T+1; resp_valid = 01 with rdata 0xDEAD_BEEF for one cycle; busy drops in the response-output cycle.
- Contention and rotation:
  - Stimulus: req_valid = 11 held for 4 transactions from reset.
  - Required: grants 0, 1, 0, 1; each resp_valid one-hot matches its grant.
- Backpressure:
  - Stimulus: mem_ready = 0 for 5 cycles after issue; requester 0 changes req_addr meanwhile.
  - Required: mem_valid stays 1 and mem_addr stays at the originally latched value until mem_ready.
- Same-cycle accept and response:
  - Stimulus: mem_ready = 1 and mem_resp_valid = 1 in the first ISSUE cycle.
  - Required: skips WAIT; resp_valid next cycle; IDLE next cycle.
- Spurious response:
  - Stimulus: mem_resp_valid pulses in IDLE.
  - Required: resp_valid stays 0; rr_ptr unchanged.
- Reset mid-WAIT:
  - Stimulus: assert rst asynchronously while in WAIT, then apply mem_resp_valid.
  - Required: all outputs are 0 immediately; the late response is ignored; the next request is granted to requester 0 first.

Source files
------------

// File: rtl/mem_port_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_rr_arbiter
//
// Shares a single memory/bus port between NR_REQ requesters, for example the
// instruction fetch unit (requester 0) and the load/store unit (requester 1).
// Arbitration is round-robin, and only one transaction is outstanding at a
// time. The winning request is latched and driven downstream. The response is
// routed back only to the requester that issued it.
//
// Ports
//   clk             clock; all state changes on the rising edge
//   rst             asynchronous, active-high reset
//   req_valid       per-requester request valid
//   req_ready       per-requester accept; at most one bit is set
//   req_addr        flattened addresses; requester i at [ADDR_W*(i+1)-1 : ADDR_W*i]
//   req_wdata       flattened write data, packed the same way
//   req_wen         per-requester write enable (1 = write, 0 = read)
//   resp_valid      one-cycle response strobe to the issuing requester
//   resp_rdata      response data, broadcast to all and qualified by resp_valid
//   mem_valid       downstream request valid
//   mem_ready       downstream accept
//   mem_addr        latched request address
//   mem_wdata       latched write data
//   mem_wen         latched write enable
//   mem_resp_valid  downstream response strobe
//   mem_resp_rdata  downstream response data
//   busy            high whenever a transaction is in flight (state != IDLE)
// -----------------------------------------------------------------------------
module mem_port_rr_arbiter #(
  parameter  int NR_REQ = 2,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 64,
  localparam int IDX_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic [NR_REQ-1:0]        req_valid,
  output logic [NR_REQ-1:0]        req_ready,
  input  logic [NR_REQ*ADDR_W-1:0] req_addr,
  input  logic [NR_REQ*DATA_W-1:0] req_wdata,
  input  logic [NR_REQ-1:0]        req_wen,
  output logic [NR_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,

  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_wen,
  input  logic                     mem_resp_valid,
  input  logic [DATA_W-1:0]        mem_resp_rdata,

  output logic                     busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_grant_idx;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_wen;
  logic [NR_REQ-1:0] r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;

  logic              w_found;
  logic [IDX_W-1:0]  w_win;
  logic [IDX_W-1:0]  w_idx;
  logic              w_fire;
  logic              w_done;
  logic [IDX_W-1:0]  w_rr_next;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_wen;

  function automatic logic [NR_REQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    logic [NR_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Winner search starting at r_rr_ptr and wrapping modulo NR_REQ. The loop
  // runs from the farthest offset down to zero, so the last hit is the
  // requester closest to the pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = NR_REQ - 1; k >= 0; k--) begin
      w_idx = IDX_W'((int'(r_rr_ptr) + k) % NR_REQ);
      if (req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Keyed mux that picks the winner's request fields
  always_comb begin
    w_sel_addr  = req_addr[int'(w_win)*ADDR_W +: ADDR_W];
    w_sel_wdata = req_wdata[int'(w_win)*DATA_W +: DATA_W];
    w_sel_wen   = req_wen[w_win];
  end

  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_found) begin
      req_ready = f_onehot(w_win);
    end
  end

  assign w_fire = (r_state == S_IDLE) && w_found;

  // Completion happens in WAIT, or in ISSUE when the accept and the response
  // land in the same cycle, in which case WAIT is skipped.
  assign w_done = ((r_state == S_WAIT) && mem_resp_valid) ||
                  ((r_state == S_ISSUE) && mem_ready && mem_resp_valid);

  assign w_rr_next = (r_grant_idx == IDX_W'(NR_REQ - 1)) ? '0 : r_grant_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_grant_idx  <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wen    <= 1'b0;
      r_resp_valid <= '0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_wen   <= w_sel_wen;
            r_grant_idx <= w_win;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            r_state <= mem_resp_valid ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // The response strobe is registered, so the requester sees it one
      // cycle after the downstream response, for exactly one cycle.
      r_resp_valid <= w_done ? f_onehot(r_grant_idx) : '0;
      if (w_done) begin
        r_resp_rdata <= mem_resp_rdata;
        r_rr_ptr     <= w_rr_next;
      end
    end
  end

  assign mem_valid  = (r_state == S_ISSUE);
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wen    = r_mem_wen;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_rr_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_rr_arbiter;

  localparam int NR_REQ = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic                     clk;
  logic                     rst;
  logic [NR_REQ-1:0]        req_valid;
  logic [NR_REQ-1:0]        req_ready;
  logic [NR_REQ*ADDR_W-1:0] req_addr;
  logic [NR_REQ*DATA_W-1:0] req_wdata;
  logic [NR_REQ-1:0]        req_wen;
  logic [NR_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]        resp_rdata;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_wen;
  logic                     mem_resp_valid;
  logic [DATA_W-1:0]        mem_resp_rdata;
  logic                     busy;

  int errors = 0;
  int checks = 0;

  mem_port_rr_arbiter #(.NR_REQ(NR_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wen(req_wen),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_wdata = '0; req_wen = '0;
    mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_wdata = '0; req_wen = '0;
    mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b expected 0", mem_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b expected 00", resp_valid); end
    checks++;
    if (resp_rdata !== 64'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 64'h0 || mem_wen !== 1'b0) begin
      errors++; $display("FAIL reset_mem_fields: got addr=%h wdata=%h wen=%b expected zeros", mem_addr, mem_wdata, mem_wen);
    end
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    #1 rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    req_valid = 2'b01;
    req_addr[31:0] = 32'h8000_0000;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready: got %b expected 01", req_ready); end
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("FAIL single_mem_valid_T: got %b expected 0", mem_valid); end
    tick();                       // handshake edge
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0) begin
      errors++; $display("FAIL single_issue: got valid=%b addr=%h wen=%b expected 1 80000000 0", mem_valid, mem_addr, mem_wen);
    end
    tick();                       // mem accepts, now waiting
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h0000_0000_DEAD_BEEF;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0 || busy !== 1'b1 || resp_valid !== 2'b00) begin
      errors++; $display("FAIL single_wait: got mem_valid=%b busy=%b resp_valid=%b expected 0 1 00", mem_valid, busy, resp_valid);
    end
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 2'b01 || resp_rdata !== 64'h0000_0000_DEAD_BEEF) begin
      errors++; $display("FAIL single_resp: got valid=%b rdata=%h expected 01 deadbeef", resp_valid, resp_rdata);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b expected 0", busy); end
    @(negedge clk);
    checks++;
    if (resp_valid !== 2'b00) begin errors++; $display("FAIL single_resp_one_cycle: got %b expected 00", resp_valid); end
  endtask

  task automatic test_rotation();
    logic [1:0]  exp_oh;
    logic [1:0]  nxt_oh;
    logic [31:0] exp_addr;
    logic [63:0] exp_wdata;
    logic        exp_wen;
    do_reset();
    req_addr  = {32'h0000_0200, 32'h0000_0100};
    req_wdata = {64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD};
    req_wen   = 2'b10;
    req_valid = 2'b11;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL rot_first_ready: got %b expected 01", req_ready); end
    for (int i = 0; i < 4; i++) begin
      exp_oh    = (i % 2 == 0) ? 2'b01 : 2'b10;
      nxt_oh    = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_addr  = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
      exp_wdata = (i % 2 == 0) ? 64'hAAAA_BBBB_CCCC_DDDD : 64'h1111_2222_3333_4444;
      exp_wen   = (i % 2 == 1);
      tick();
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== exp_wdata || mem_wen !== exp_wen) begin
        errors++; $display("FAIL rot_issue[%0d]: got valid=%b addr=%h wdata=%h wen=%b expected 1 %h %h %b",
                           i, mem_valid, mem_addr, mem_wdata, mem_wen, exp_addr, exp_wdata, exp_wen);
      end
      tick();
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 64'h50 + 64'(i);
      tick();
      mem_resp_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_valid !== exp_oh || resp_rdata !== 64'h50 + 64'(i)) begin
        errors++; $display("FAIL rot_resp[%0d]: got valid=%b rdata=%h expected %b %h", i, resp_valid, resp_rdata, exp_oh, 64'h50 + 64'(i));
      end
      // A new acceptance may coincide with the response strobe
      checks++;
      if (req_ready !== nxt_oh) begin errors++; $display("FAIL rot_next_ready[%0d]: got %b expected %b", i, req_ready, nxt_oh); end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_addr[31:0] = 32'h0000_A000;
    req_valid = 2'b01;
    mem_ready = 1'b0;
    tick();                       // handshake edge
    req_addr[31:0] = 32'h0000_BBBB;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_A000) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid=%b addr=%h expected 1 0000a000", i, mem_valid, mem_addr);
      end
    end
    req_valid = 2'b00;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_to_wait: got mem_valid=%b busy=%b expected 0 1", mem_valid, busy);
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h77;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    checks++;
    if (resp_valid !== 2'b01 || resp_rdata !== 64'h77 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_resp: got valid=%b rdata=%h busy=%b expected 01 77 0", resp_valid, resp_rdata, busy);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    req_addr[63:32] = 32'h0000_C000;
    req_valid = 2'b10;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL same_ready: got %b expected 10", req_ready); end
    tick();                       // handshake edge
    req_valid = 2'b00;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h1234;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_C000) begin
      errors++; $display("FAIL same_issue: got valid=%b addr=%h expected 1 0000c000", mem_valid, mem_addr);
    end
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 2'b10 || resp_rdata !== 64'h1234 || busy !== 1'b0 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL same_complete: got valid=%b rdata=%h busy=%b mem_valid=%b expected 10 1234 0 0",
                         resp_valid, resp_rdata, busy, mem_valid);
    end
    // grant 1 wraps the pointer back to 0
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL same_wrap_ptr: got %b expected 01", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_spurious();
    do_reset();
    req_valid = 2'b01;
    mem_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h9;
    tick();
    mem_resp_valid = 1'b0;        // pointer now 1, back in IDLE
    tick();
    mem_resp_valid = 1'b1;        // spurious pulse in IDLE
    mem_resp_rdata = 64'hBAD;
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 2'b00 || resp_rdata !== 64'h9) begin
      errors++; $display("FAIL spur_resp: got valid=%b rdata=%h expected 00 9", resp_valid, resp_rdata);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL spur_ptr: got %b expected 10", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    req_addr = {32'h0000_1110, 32'h0000_2220};
    req_valid = 2'b10;
    mem_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();                       // now in WAIT
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL rstw_in_wait: got busy=%b mem_valid=%b expected 1 0", busy, mem_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_valid !== 1'b0 || mem_addr !== 32'h0 || resp_valid !== 2'b00 || req_ready !== 2'b00) begin
      errors++; $display("FAIL rstw_async: got busy=%b mem_valid=%b addr=%h resp_valid=%b req_ready=%b expected all 0",
                         busy, mem_valid, mem_addr, resp_valid, req_ready);
    end
    tick();
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hFEED;
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 2'b00 || resp_rdata !== 64'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstw_late_resp: got valid=%b rdata=%h busy=%b expected 00 0 0", resp_valid, resp_rdata, busy);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL rstw_next_grant: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_2220) begin
      errors++; $display("FAIL rstw_next_issue: got valid=%b addr=%h expected 1 00002220", mem_valid, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rotation();
    test_backpressure();
    test_same_cycle();
    test_spurious();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
